// File: rtl/racer_pkg.sv
// Shared encodings for the racer game-flow blocks: screen states and control schemes.
package racer_pkg;

    localparam logic [2:0] SPLASH         = 3'd0;
    localparam logic [2:0] CAR_SELECT     = 3'd1;
    localparam logic [2:0] CONTROL_SELECT = 3'd2;
    localparam logic [2:0] COUNTDOWN      = 3'd3;
    localparam logic [2:0] GAME           = 3'd4;
    localparam logic [2:0] FINISH         = 3'd5;

    localparam logic CTRL_KEYBOARD = 1'b0;
    localparam logic CTRL_MOUSE    = 1'b1;

    typedef enum logic [2:0] {
        StSplash        = SPLASH,
        StCarSelect     = CAR_SELECT,
        StControlSelect = CONTROL_SELECT,
        StCountdown     = COUNTDOWN,
        StGame          = GAME,
        StFinish        = FINISH
    } state_t;

endpackage

// File: rtl/btn_edge.sv
// Registered rising-edge detector for a debounced button level.
module btn_edge (
    input  logic pclk,
    input  logic rst,
    input  logic level,
    output logic pulse
);

    logic prev_q;
    logic armed_q;
    logic pulse_q;

    // armed_q masks the first cycle after reset so a button held through reset is not an edge.
    always_ff @(posedge pclk) begin
        if (rst) begin
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            prev_q  <= level;
            armed_q <= 1'b1;
            pulse_q <= level & ~prev_q & armed_q;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/screen_sequencer.sv
// Racer game-flow controller: splash, car/control selection, countdown, race and finish screens.
module screen_sequencer
    import racer_pkg::*;
#(
    parameter int unsigned SPLASH_FRAMES = 180,
    parameter int unsigned DIGIT_FRAMES  = 60,
    parameter int unsigned FINISH_FRAMES = 300,
    parameter int unsigned NUM_CARS      = 4
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       btn_confirm,
    input  logic       race_finished,
    output logic       splash_visible,
    output logic       car_select_visible,
    output logic       control_select_visible,
    output logic       track_visible,
    output logic       player_visible,
    output logic       finish_visible,
    output logic [1:0] countdown_digit,
    output logic [1:0] car_sel,
    output logic       control_sel,
    output logic       player_enable,
    output logic       game_start
);

    localparam int unsigned COUNTDOWN_FRAMES = 3 * DIGIT_FRAMES;
    localparam int unsigned MAX_SF = (SPLASH_FRAMES > FINISH_FRAMES) ? SPLASH_FRAMES
                                                                     : FINISH_FRAMES;
    localparam int unsigned MAX_FRAMES = (MAX_SF > COUNTDOWN_FRAMES) ? MAX_SF : COUNTDOWN_FRAMES;
    localparam int unsigned CNT_W = (MAX_FRAMES > 2) ? $clog2(MAX_FRAMES) : 1;

    localparam logic [1:0]       LAST_CAR    = 2'(NUM_CARS - 1);
    localparam logic [CNT_W-1:0] SPLASH_LAST = CNT_W'(SPLASH_FRAMES - 1);
    localparam logic [CNT_W-1:0] CD_LAST     = CNT_W'(COUNTDOWN_FRAMES - 1);
    localparam logic [CNT_W-1:0] FINISH_LAST = CNT_W'(FINISH_FRAMES - 1);
    localparam logic [CNT_W-1:0] DIGIT2_AT   = CNT_W'(DIGIT_FRAMES);
    localparam logic [CNT_W-1:0] DIGIT1_AT   = CNT_W'(2 * DIGIT_FRAMES);

    logic next_edge, prev_edge, confirm_edge;

    btn_edge u_next_edge (
        .pclk  (pclk),
        .rst   (rst),
        .level (btn_next),
        .pulse (next_edge)
    );

    btn_edge u_prev_edge (
        .pclk  (pclk),
        .rst   (rst),
        .level (btn_prev),
        .pulse (prev_edge)
    );

    btn_edge u_confirm_edge (
        .pclk  (pclk),
        .rst   (rst),
        .level (btn_confirm),
        .pulse (confirm_edge)
    );

    state_t           state_q, state_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [1:0]       car_sel_q, car_sel_d;
    logic             control_sel_q, control_sel_d;

    logic splash_done, countdown_done, finish_done;
    assign splash_done    = frame_tick && (frame_cnt_q == SPLASH_LAST);
    assign countdown_done = frame_tick && (frame_cnt_q == CD_LAST);
    assign finish_done    = frame_tick && (frame_cnt_q == FINISH_LAST);

    always_comb begin
        state_d       = state_q;
        car_sel_d     = car_sel_q;
        control_sel_d = control_sel_q;
        case (state_q)
            StSplash: begin
                if (confirm_edge || splash_done) state_d = StCarSelect;
            end
            StCarSelect: begin
                // Confirm takes priority and freezes the selection for that cycle.
                if (confirm_edge) begin
                    state_d = StControlSelect;
                end else if (next_edge && !prev_edge) begin
                    car_sel_d = (car_sel_q == LAST_CAR) ? 2'd0 : car_sel_q + 2'd1;
                end else if (prev_edge && !next_edge) begin
                    car_sel_d = (car_sel_q == 2'd0) ? LAST_CAR : car_sel_q - 2'd1;
                end
            end
            StControlSelect: begin
                if (confirm_edge) begin
                    state_d = StCountdown;
                end else if (next_edge ^ prev_edge) begin
                    control_sel_d = (control_sel_q == CTRL_KEYBOARD) ? CTRL_MOUSE : CTRL_KEYBOARD;
                end
            end
            StCountdown: begin
                if (countdown_done) state_d = StGame;
            end
            StGame: begin
                if (race_finished) state_d = StFinish;
            end
            StFinish: begin
                if (confirm_edge || finish_done) state_d = StCarSelect;
            end
            default: begin
                state_d       = StSplash;
                car_sel_d     = 2'd0;
                control_sel_d = CTRL_KEYBOARD;
            end
        endcase

        if (state_d != state_q) begin
            frame_cnt_d = '0;
        end else if (frame_tick) begin
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q       <= StSplash;
            frame_cnt_q   <= '0;
            car_sel_q     <= 2'd0;
            control_sel_q <= CTRL_KEYBOARD;
        end else begin
            state_q       <= state_d;
            frame_cnt_q   <= frame_cnt_d;
            car_sel_q     <= car_sel_d;
            control_sel_q <= control_sel_d;
        end
    end

    // Registered output decode; lags the state register by one cycle.
    logic [5:0] vis_d, vis_q;
    logic [1:0] digit_d, digit_q;
    logic       player_enable_d, player_enable_q;
    logic       game_start_d, game_start_q;

    always_comb begin
        vis_d           = 6'b000000;
        digit_d         = 2'd0;
        player_enable_d = 1'b0;
        game_start_d    = 1'b0;
        case (state_q)
            StSplash:        vis_d = 6'b100000;
            StCarSelect:     vis_d = 6'b010000;
            StControlSelect: vis_d = 6'b001000;
            StCountdown: begin
                vis_d = 6'b000110;
                if (frame_cnt_q < DIGIT2_AT) begin
                    digit_d = 2'd3;
                end else if (frame_cnt_q < DIGIT1_AT) begin
                    digit_d = 2'd2;
                end else begin
                    digit_d = 2'd1;
                end
            end
            StGame: begin
                vis_d           = 6'b000110;
                player_enable_d = 1'b1;
                game_start_d    = ~player_enable_q;
            end
            StFinish:        vis_d = 6'b000111;
            default:         vis_d = 6'b000000;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            vis_q           <= 6'b000000;
            digit_q         <= 2'd0;
            player_enable_q <= 1'b0;
            game_start_q    <= 1'b0;
        end else begin
            vis_q           <= vis_d;
            digit_q         <= digit_d;
            player_enable_q <= player_enable_d;
            game_start_q    <= game_start_d;
        end
    end

    assign splash_visible         = vis_q[5];
    assign car_select_visible     = vis_q[4];
    assign control_select_visible = vis_q[3];
    assign track_visible          = vis_q[2];
    assign player_visible         = vis_q[1];
    assign finish_visible         = vis_q[0];
    assign countdown_digit        = digit_q;
    assign car_sel                = car_sel_q;
    assign control_sel            = control_sel_q;
    assign player_enable          = player_enable_q;
    assign game_start             = game_start_q;

endmodule
